// File: rtl/rom_arbiter_rr_pkg.sv
// Shared constants for the round-robin ROM arbiter: FSM encodings and default sizes.
// No logic here, so no latency or backpressure behaviour of its own.
package rom_arbiter_rr_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 4;

endpackage

// File: rtl/rom_arbiter_rr_if.sv
// Requester-side bundle of the ROM arbiter: per-requester req/addr in, one-hot ack and shared data out.
// Pure wiring; ack is a one-cycle pulse with no backpressure, req is held until ack.
interface rom_arbiter_rr_if
    import rom_arbiter_rr_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        ack;
    logic [DATA_W-1:0]       rd_data;
    logic                    busy;

    modport master (
        output req,
        output req_addr,
        input  ack,
        input  rd_data,
        input  busy
    );

    modport slave (
        input  req,
        input  req_addr,
        output ack,
        output rd_data,
        output busy
    );
endinterface

// File: rtl/rom_arbiter_rr_pick.sv
// Rotated priority scan: first asserted req starting at last+1, wrapping N_REQ-1 -> 0.
// Purely combinational, zero latency, no backpressure.
module rr_pick
    import rom_arbiter_rr_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int j;

    // Walk from the farthest candidate (last itself) toward last+1 so the nearest one wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = int'(last) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req[j[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rom_arbiter_rr.sv
// Round-robin arbiter sharing one async-read ROM among N_REQ requesters; ack pulses 2 cycles after grant.
// One read per 3 cycles; requesters hold req until ack, withdrawing in READ aborts without ack.
module rom_arbiter_rr
    import rom_arbiter_rr_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    rom_arbiter_rr_if.slave   bus,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [1:0]       state;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] last;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [ADDR_W-1:0] addr_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_addr
        assign addr_arr[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .last  (last),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign bus.busy = (state == S_READ) || (state == S_RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            gnt_idx     <= '0;
            last        <= IDX_W'(N_REQ - 1);
            rom_addr    <= '0;
            bus.rd_data <= '0;
            bus.ack     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.ack <= '0;
                    if (pick_vld) begin
                        gnt_idx  <= pick_idx;
                        rom_addr <= addr_arr[pick_idx];
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    if (bus.req[gnt_idx]) begin
                        bus.rd_data <= rom_data;
                        // Ack is registered here so it is high exactly during RESP.
                        bus.ack     <= N_REQ'(1) << gnt_idx;
                        state       <= S_RESP;
                    end else begin
                        last  <= gnt_idx;
                        state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    bus.ack <= '0;
                    last    <= gnt_idx;
                    state   <= S_IDLE;
                end
                default: begin
                    bus.ack <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter_rr.sv
// Directed scoreboard bench for rom_arbiter_rr with a 4-word ROM (A,5,3,C) and four requesters.
module tb_rom_arbiter_rr;

    logic       clk;
    logic       rst_n;
    logic [1:0] rom_addr;
    logic [3:0] rom_data;

    rom_arbiter_rr_if #(.N_REQ(4), .ADDR_W(2), .DATA_W(4)) bus ();

    rom_arbiter_rr #(.N_REQ(4), .ADDR_W(2), .DATA_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    function automatic logic [3:0] rom_word(input logic [1:0] a);
        case (a)
            2'd0:    rom_word = 4'hA;
            2'd1:    rom_word = 4'h5;
            2'd2:    rom_word = 4'h3;
            default: rom_word = 4'hC;
        endcase
    endfunction

    assign rom_data = rom_word(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ack;
        logic [3:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [7:0] pack(input logic [1:0] a0, input logic [1:0] a1,
                                        input logic [1:0] a2, input logic [1:0] a3);
        pack = {a3, a2, a1, a0};
    endfunction

    task automatic push(input logic [3:0] a, input logic [3:0] d);
        exp_t e;
        e.ack  = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Monitor: every ack pulse must match the next expected response in order.
    always @(negedge clk) begin
        if ((|bus.ack) === 1'b1) begin
            exp_t e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack: got ack=%b data=%h want none", bus.ack, bus.rd_data);
            end else begin
                e = q.pop_front();
                if (bus.ack !== e.ack || bus.rd_data !== e.data) begin
                    bad++;
                    $display("FAIL sb_resp: got ack=%b data=%h want ack=%b data=%h",
                             bus.ack, bus.rd_data, e.ack, e.data);
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.req      = 4'hF;
        bus.req_addr = '0;

        // Reset with all requests asserted
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("rst_ack", bus.ack, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_rd_data", bus.rd_data, 0);
            chk("rst_rom_addr", rom_addr, 0);
            @(posedge clk);
        end
        #1;
        rst_n   = 1'b1;
        bus.req = 4'h0;

        // Single request, timing of busy and ack
        bus.req_addr = pack(2, 0, 0, 0);
        bus.req      = 4'b0001;
        push(4'b0001, 4'h3);
        step(1);
        chk("t2_busy_read", bus.busy, 1);
        chk("t2_no_early_ack", bus.ack, 0);
        step(1);
        chk("t2_ack", bus.ack, 4'b0001);
        chk("t2_busy_resp", bus.busy, 1);
        bus.req = 4'b0000;
        step(1);
        chk("t2_ack_low", bus.ack, 0);
        chk("t2_busy_idle", bus.busy, 0);

        // All four held: strict rotation, 3 cycles apart
        do_reset();
        bus.req_addr = pack(3, 2, 1, 0);
        push(4'b0001, 4'hC);
        push(4'b0010, 4'h3);
        push(4'b0100, 4'h5);
        push(4'b1000, 4'hA);
        push(4'b0001, 4'hC);
        bus.req = 4'hF;
        step(2);
        chk("t3_ack0", bus.ack, 4'b0001);
        step(3);
        chk("t3_ack1", bus.ack, 4'b0010);
        step(3);
        chk("t3_ack2", bus.ack, 4'b0100);
        step(3);
        chk("t3_ack3", bus.ack, 4'b1000);
        step(3);
        chk("t3_ack4", bus.ack, 4'b0001);
        bus.req = 4'h0;
        step(1);
        chk("t3_ack_low", bus.ack, 0);
        chk("t3_idle", bus.busy, 0);

        // Wrap-around from last=3, then a lone requester held
        do_reset();
        bus.req_addr = pack(0, 0, 0, 3);
        push(4'b0001, 4'hA);
        push(4'b1000, 4'hC);
        bus.req = 4'b1001;
        step(2);
        chk("t4_wrap_ack0", bus.ack, 4'b0001);
        bus.req = 4'b1000;
        step(3);
        chk("t4_wrap_ack3", bus.ack, 4'b1000);
        bus.req = 4'b0000;
        step(1);
        chk("t4_ack_low", bus.ack, 0);

        bus.req_addr = pack(0, 0, 1, 0);
        push(4'b0100, 4'h5);
        push(4'b0100, 4'h5);
        push(4'b0100, 4'h5);
        bus.req = 4'b0100;
        step(2);
        chk("t4_solo_a", bus.ack, 4'b0100);
        step(3);
        chk("t4_solo_b", bus.ack, 4'b0100);
        step(3);
        chk("t4_solo_c", bus.ack, 4'b0100);
        bus.req = 4'b0000;
        step(1);
        chk("t4_solo_low", bus.ack, 0);

        // Withdraw during READ: no ack, data held, back to IDLE
        bus.req_addr = pack(0, 3, 0, 0);
        bus.req      = 4'b0010;
        step(1);
        chk("t5_busy_read", bus.busy, 1);
        bus.req = 4'b0000;
        step(1);
        chk("t5_no_ack", bus.ack, 0);
        chk("t5_idle", bus.busy, 0);
        chk("t5_rd_data_held", bus.rd_data, 4'h5);
        chk("t5_rom_addr_held", rom_addr, 3);

        bus.req_addr = pack(3, 0, 0, 0);
        push(4'b0001, 4'hC);
        push(4'b0010, 4'hA);
        bus.req = 4'b0011;
        step(2);
        chk("t5_after_withdraw_req0", bus.ack, 4'b0001);
        bus.req = 4'b0010;
        step(3);
        chk("t5_then_req1", bus.ack, 4'b0010);
        bus.req = 4'b0000;
        step(1);
        chk("t5_ack_low", bus.ack, 0);

        // Reset during RESP of requester 1: last returns to 3, so req1 wins next
        bus.req_addr = pack(0, 3, 0, 0);
        push(4'b0010, 4'hC);
        bus.req = 4'b0010;
        step(2);
        chk("t6_resp_ack", bus.ack, 4'b0010);
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        step(1);
        chk("t6_rst_ack", bus.ack, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_rd_data", bus.rd_data, 0);
        chk("t6_rst_rom_addr", rom_addr, 0);
        rst_n = 1'b1;

        bus.req_addr = pack(0, 2, 1, 0);
        push(4'b0010, 4'h3);
        push(4'b0100, 4'h5);
        bus.req = 4'b0110;
        step(2);
        chk("t6_first_req1", bus.ack, 4'b0010);
        bus.req = 4'b0100;
        step(3);
        chk("t6_then_req2", bus.ack, 4'b0100);
        bus.req = 4'b0000;
        step(1);
        chk("t6_ack_low", bus.ack, 0);

        step(3);
        chk("sb_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
